// File: rtl/alu_seq_pkg.sv
// Shared opcodes, instruction field layout and FSM state type for the ALU sequencer.
package alu_seq_pkg;

  localparam int INSTR_W = 17;
  localparam int OPC_MSB = 16;
  localparam int OPC_LSB = 14;
  localparam int IMM_W   = 14;
  localparam int GAIN    = 100;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_SET  = 3'b101;
  localparam logic [2:0] OP_EQU  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  function automatic logic [2:0] opcodeOf(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [IMM_W-1:0] immOf(input logic [INSTR_W-1:0] instr);
    return instr[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Program-memory fetch handshake and ALU operand/result bus between sequencer and its peers.
interface alu_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 14
);

  logic               instr_req;
  logic [PC_W-1:0]    instr_addr;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;

  logic [2:0]         alu_op;
  logic [DATA_W-1:0]  alu_in1;
  logic [DATA_W-1:0]  alu_in2;
  logic [DATA_W-1:0]  alu_out;

  modport master (
    output instr_req, instr_addr, alu_op, alu_in1, alu_in2,
    input  instr_valid, instr_data, alu_out
  );

  modport slave (
    input  instr_req, instr_addr, alu_op, alu_in1, alu_in2,
    output instr_valid, instr_data, alu_out
  );

endinterface

// File: rtl/alu_seq_decode.sv
// Combinational instruction-register decode: classifies the opcode for EXEC/WB handling.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output logic               is_halt_o,
  output logic               is_wb_acc_o,
  output logic               is_set_o,
  output logic               is_equ_o,
  output logic               div_zero_o
);

  logic [2:0]       opc;
  logic [IMM_W-1:0] imm;

  assign opc = opcodeOf(ir_i);
  assign imm = immOf(ir_i);

  always_comb begin
    is_halt_o   = 1'b0;
    is_wb_acc_o = 1'b0;
    is_set_o    = 1'b0;
    is_equ_o    = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD: is_wb_acc_o = 1'b1;
      OP_SET:                                  is_set_o    = 1'b1;
      OP_EQU:                                  is_equ_o    = 1'b1;
      OP_HALT:                                 is_halt_o   = 1'b1;
      default:                                 is_wb_acc_o = 1'b0;
    endcase
  end

  assign div_zero_o = (opc == OP_DIV) && (imm == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/exec/writeback control for the soft-processor ALU; accumulator, pc and skip live here.
// Optional retired-instruction counter enabled with `define ALU_SEQ_RETIRE_CNT_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  alu_sequencer_if.master   bus,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy,
  output logic              halted,
  output logic              div_err
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               skip_q, skip_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_W-1:0]  in1_q, in1_d;
  logic [DATA_W-1:0]  in2_q, in2_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               rvalid_q, rvalid_d;
  logic               diverr_q, diverr_d;

  logic is_halt, is_wb_acc, is_set, is_equ, div_zero;
  logic restart;

  alu_seq_decode u_decode (
    .ir_i        (ir_q),
    .is_halt_o   (is_halt),
    .is_wb_acc_o (is_wb_acc),
    .is_set_o    (is_set),
    .is_equ_o    (is_equ),
    .div_zero_o  (div_zero)
  );

  assign restart = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    skip_d   = skip_q;
    ir_d     = ir_q;
    op_d     = op_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    result_d = result_q;
    rvalid_d = 1'b0;
    diverr_d = diverr_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        // A pending skip from the previous run must not leak into the new one.
        if (restart) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          acc_d    = '0;
          skip_d   = 1'b0;
          diverr_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (skip_q) begin
          skip_d  = 1'b0;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else if (div_zero) begin
          diverr_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          // ALU operands only change on the path to WB, so HALT and divide-by-zero never reach it.
          op_d    = opcodeOf(ir_q);
          in1_d   = DATA_W'($signed(immOf(ir_q)));
          in2_d   = acc_q;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (is_wb_acc) acc_d = bus.alu_out;
        if (is_set) begin
          result_d = acc_q;
          rvalid_d = 1'b1;
        end
        if (is_equ) skip_d = bus.alu_out[0];
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      acc_q    <= '0;
      skip_q   <= 1'b0;
      ir_q     <= '0;
      op_q     <= OP_LOAD;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      diverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      skip_q   <= skip_d;
      ir_q     <= ir_d;
      op_q     <= op_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      diverr_q <= diverr_d;
    end
  end

`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_q, retire_d;

  // Skipped words never reach WB; HALT retires in its EXEC cycle since it has no WB.
  always_comb begin
    retire_d = retire_q;
    if (restart) begin
      retire_d = '0;
    end else if ((state_q == ST_EXEC) && !skip_q && is_halt) begin
      retire_d = retire_q + 16'd1;
    end else if (state_q == ST_WB) begin
      retire_d = retire_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_q <= '0;
    else        retire_q <= retire_d;
  end

  assign retire_cnt = retire_q;
`endif

  assign bus.instr_req  = (state_q == ST_FETCH);
  assign bus.instr_addr = pc_q;
  assign bus.alu_op     = op_q;
  assign bus.alu_in1    = in1_q;
  assign bus.alu_in2    = in2_q;

  assign result       = result_q;
  assign result_valid = rvalid_q;
  assign busy         = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_WB);
  assign halted       = (state_q == ST_HALT);
  assign div_err      = diverr_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control end of the 14-bit signed ALU interface.
- Fetches 17-bit instruction words from program memory over a req/valid handshake, then decodes them.
- Drives ALU op/in1/in2 with the immediate and the accumulator, and writes the ALU result back into the accumulator.
- Exposes the accumulator on SET and handles EQU-skip, HALT and divide-by-zero; sits between program ROM and the ALU in the soft processor.

Parameters:
- PC_W, 8, program counter width; program space 2**PC_W words.
- DATA_W, 14, operand/accumulator width (signed, gain-100 fixed point).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; leaves IDLE/HALT, pc<=0.
- instr_req  out  1  fetch request; held until instr_valid.
- instr_addr  out  PC_W  fetch address (= pc).
- instr_valid  in  1  instruction word valid this cycle.
- instr_data  in  17  [16:14] opcode, [13:0] signed immediate.
- alu_op  out  3  opcode to ALU.
- alu_in1  out  DATA_W  immediate operand.
- alu_in2  out  DATA_W  accumulator (feedback operand).
- alu_out  in  DATA_W  combinational ALU result.
- result  out  DATA_W  accumulator snapshot taken on SET.
- result_valid  out  1  one-cycle strobe with result.
- busy  out  1  high in FETCH/EXEC/WB.
- halted  out  1  high in HALT.
- div_err  out  1  sticky; set on DIV with immediate 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=0, acc=0, skip=0.
  - All outputs 0 except alu_op=3'b100.
  - Reset mid-instruction aborts with no writeback.
- Opcodes: 000 ADD, 001 SUB (acc-imm), 010 MUL, 011 DIV (acc*100/imm), 100 LOAD, 101 SET, 110 EQU, 111 HALT.
  - HALT is decoded here and never sent to the ALU.
- States: IDLE, FETCH, EXEC, WB, HALT.
- IDLE --start--> FETCH, with pc=0, acc=0 and div_err cleared.
- FETCH:
  - instr_req=1, instr_addr=pc; instr_data is latched into the instruction register on instr_valid.
  - Minimum one cycle; instr_valid may arrive any number of cycles later.
  - Next state is EXEC.
- EXEC (1 cycle): alu_op/in1/in2 are registered from the IR and acc.
  - If skip=1: clear skip, pc<=pc+1, go to FETCH; ALU result ignored.
  - HALT: go to HALT; pc unchanged.
  - DIV with imm==0: div_err<=1, go to HALT; ALU not consulted.
- WB (1 cycle): alu_out is sampled.
  - ADD/SUB/MUL/DIV/LOAD: acc<=alu_out.
  - SET: result<=acc, result_valid=1 for this cycle; acc unchanged.
  - EQU: skip<=alu_out[0]; acc unchanged.
  - Then pc<=pc+1 and go to FETCH.
- Throughput: one instruction per FETCH+2 cycles; with zero-wait memory this is 3 cycles per instruction.
- pc wraps from 2**PC_W-1 to 0 silently.
- Overflow: the ALU result is taken as-is (ALU truncates to DATA_W); no saturation here.
- start is ignored while busy.
- start in HALT restarts from pc=0 and clears div_err.
- A skip pending when HALT is reached is discarded on restart.
- instr_valid is ignored outside FETCH.

Optional Feature:
- Macro: ALU_SEQ_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt (16 bits).
  - Increments in WB of every non-skipped instruction; HALT counts too, in its EXEC cycle.
  - Wraps at 16'hFFFF->0; cleared by reset and by start.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_ADD..OP_HALT;
  - state enum (IDLE, FETCH, EXEC, WB, HALT);
  - field slices OPC_MSB/OPC_LSB, IMM_W=14, GAIN=100.
- Natural sub-module: alu_seq_decode.
  - Combinational; takes the IR.
  - Outputs is_halt, is_wb_acc, is_set, is_equ, div_zero.
- FSM, pc, acc, skip and result registers stay in the top module.

Test Plan:
- LOAD 250, MUL 200, SET, HALT, zero-wait memory (ALU mock: in2*in1/100):
  - result=500 strobed once; halted=1;
  - HALT's EXEC cycle occurs 11 cycles after start.
- LOAD 300, EQU 300, LOAD 7, SET, HALT:
  - LOAD 7 is skipped; result=300; pc advances past the skipped word.
- LOAD 100, DIV 0:
  - div_err=1, halted=1, acc stays 100;
  - alu_op never shows 011 with in1=0 in WB.
- Memory with 4-cycle instr_valid latency:
  - instr_req held high 4 cycles per fetch, instr_addr stable;
  - results identical to zero-wait run.
- PC_W=2, program of four ADD 1 with no HALT:
  - pc wraps 3->0 and acc increments continuously;
  - rst_n pulled low mid-EXEC gives acc=0, pc=0, state IDLE, outputs 0 asynchronously.
- ALU_SEQ_RETIRE_CNT_EN defined, LOAD 5, SUB 2, SET, HALT:
  - retire_cnt=4; result=3.
